// File: rtl/cast_scheduler_pkg.sv
// Shared constants, result type and saturating cast helpers for cast_scheduler.
// Latency: n/a (package of pure functions and constants).
// Backpressure: n/a.
//
// The cast works on a CAST_W-bit signed container so that one function can serve
// any input/output format up to that width. DIN_WIDTH plus any fractional
// left-shift must fit in CAST_W.
package cast_sched_pkg;

   localparam int N_LANES_DEF       = 4;
   localparam int DIN_WIDTH_DEF     = 32;
   localparam int DIN_POINT_DEF     = 16;
   localparam int DOUT_WIDTH_DEF    = 16;
   localparam int DOUT_POINT_DEF    = 11;
   localparam int SAT_CNT_WIDTH_DEF = 16;

   localparam int LANE_W   = $clog2(N_LANES_DEF);
   localparam int DIN_INT  = DIN_WIDTH_DEF - DIN_POINT_DEF;
   localparam int DOUT_INT = DOUT_WIDTH_DEF - DOUT_POINT_DEF;

   localparam int CAST_W = 64;

   typedef struct packed {
      logic              sat;
      logic [CAST_W-1:0] val;
   } cast_res_t;

   // Largest positive value of a w-bit signed word: 0111...1.
   function automatic logic signed [CAST_W-1:0] out_max(input int w);
      logic signed [CAST_W-1:0] m;
      m = '1;
      m = m >> (CAST_W - w + 1);
      return m;
   endfunction

   // Most negative value of a w-bit signed word: 1000...0.
   function automatic logic signed [CAST_W-1:0] out_min(input int w);
      return ~out_max(w);
   endfunction

   // Requantize x (in_point fractional bits) to out_w bits with out_point
   // fractional bits. Dropped fraction bits are truncated (arithmetic shift,
   // i.e. toward -inf); extra fraction bits are zero-filled. Anything outside
   // the output word's range clamps to max/min and flags sat.
   function automatic cast_res_t sat_cast(input logic signed [CAST_W-1:0] x,
                                          input int in_point,
                                          input int out_w,
                                          input int out_point);
      logic signed [CAST_W-1:0] y;
      cast_res_t                r;
      if (out_point >= in_point) y = x <<< (out_point - in_point);
      else                       y = x >>> (in_point - out_point);
      r.sat = 1'b0;
      r.val = y;
      if (y > out_max(out_w)) begin
         r.sat = 1'b1;
         r.val = out_max(out_w);
      end else if (y < out_min(out_w)) begin
         r.sat = 1'b1;
         r.val = out_min(out_w);
      end
      return r;
   endfunction

endpackage

// File: rtl/cast_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after ptr.
// Latency: grant is combinational from req; ptr updates on the advance edge.
// Backpressure: ptr only moves when advance (a real transfer) is asserted.
//
// Ports: req[N] requests, advance = granted lane transferred this cycle,
//        grant[N] one-hot, grant_idx encoded winner (0 when nothing granted).
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr;
   logic          found;
   int            idx;

   // Rotating priority search starting at ptr, wrapping modulo N.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found        = 1'b1;
            grant[idx]   = 1'b1;
            grant_idx    = IW'(idx);
         end
      end
   end

   // Winner gets lowest priority next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/cast_scheduler.sv
// Shares one saturating fixed-point cast among N_LANES streams, round-robin.
// Latency: 1 cycle from transfer edge to dout_valid; 1 word/cycle sustained.
// Backpressure: din_ready drops for all lanes while dout is held (valid & ~ready).
//
// Ports: din/din_valid/din_ready per lane (lane i at [i*DIN_WIDTH +: DIN_WIDTH]),
//        lane_mask gates eligibility, dout/dout_lane/dout_sat/dout_valid/dout_ready
//        output stream, sat_cnt per-lane saturation counters, sat_clr clears them.
module cast_scheduler
   import cast_sched_pkg::*;
#(
   parameter int N_LANES       = N_LANES_DEF,
   parameter int DIN_WIDTH     = DIN_WIDTH_DEF,
   parameter int DIN_POINT     = DIN_POINT_DEF,
   parameter int DOUT_WIDTH    = DOUT_WIDTH_DEF,
   parameter int DOUT_POINT    = DOUT_POINT_DEF,
   parameter int SAT_CNT_WIDTH = SAT_CNT_WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_LANES*DIN_WIDTH-1:0]     din,
   input  logic [N_LANES-1:0]               din_valid,
   output logic [N_LANES-1:0]               din_ready,
   input  logic [N_LANES-1:0]               lane_mask,
   output logic [DOUT_WIDTH-1:0]            dout,
   output logic [$clog2(N_LANES)-1:0]       dout_lane,
   output logic                             dout_sat,
   output logic                             dout_valid,
   input  logic                             dout_ready,
   output logic [N_LANES*SAT_CNT_WIDTH-1:0] sat_cnt,
   input  logic                             sat_clr
);

   localparam int LW = $clog2(N_LANES);

   logic [N_LANES-1:0]   eligible;
   logic [N_LANES-1:0]   grant;
   logic [LW-1:0]        grant_idx;
   logic                 free;
   logic                 xfer;
   logic [DIN_WIDTH-1:0] sel_word;
   cast_res_t            cast_res;

   assign eligible = din_valid & lane_mask;
   assign free     = ~dout_valid | dout_ready;

   // rst_n gating keeps din_ready low throughout reset, when dout_valid=0
   // would otherwise make the slot look free.
   always_comb begin
      din_ready = '0;
      if (rst_n && free) din_ready = grant;
   end

   assign xfer = |(din_valid & din_ready);

   rr_arbiter #(
      .N(N_LANES)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (eligible),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign sel_word = din[grant_idx*DIN_WIDTH +: DIN_WIDTH];
   assign cast_res = sat_cast(CAST_W'($signed(sel_word)), DIN_POINT, DOUT_WIDTH, DOUT_POINT);

   // Output register: load on transfer, drop valid when drained, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_lane  <= '0;
         dout_sat   <= 1'b0;
         dout_valid <= 1'b0;
      end else if (xfer) begin
         dout       <= cast_res.val[DOUT_WIDTH-1:0];
         dout_lane  <= grant_idx;
         dout_sat   <= cast_res.sat;
         dout_valid <= 1'b1;
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

   // Per-lane saturation counters; sticky at all-ones, clear wins over increment.
   for (genvar i = 0; i < N_LANES; i++) begin : g_cnt
      logic [SAT_CNT_WIDTH-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (sat_clr) begin
            cnt_q <= '0;
         end else if (xfer && cast_res.sat && (grant_idx == LW'(i)) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + SAT_CNT_WIDTH'(1);
         end
      end

      assign sat_cnt[i*SAT_CNT_WIDTH +: SAT_CNT_WIDTH] = cnt_q;
   end

endmodule

// File: tb/tb_cast_scheduler.sv
// Self-checking bench for cast_scheduler: vector table, directed corner
// sequences, then randomized traffic against a behavioural model.
module tb_cast_scheduler;
   import cast_sched_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int OW = 16;
   localparam int SW = 16;
   localparam longint SCALE = 32;     // 2^(input point - output point) = 2^(16-11)
   localparam longint OMAX  = 32767;
   localparam longint OMIN  = -32768;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N*DW-1:0]   din;
   logic [N-1:0]      din_valid;
   logic [N-1:0]      din_ready;
   logic [N-1:0]      lane_mask;
   logic [OW-1:0]     dout;
   logic [LANE_W-1:0] dout_lane;
   logic              dout_sat;
   logic              dout_valid;
   logic              dout_ready;
   logic [N*SW-1:0]   sat_cnt;
   logic              sat_clr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cast_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .lane_mask  (lane_mask),
      .dout       (dout),
      .dout_lane  (dout_lane),
      .dout_sat   (dout_sat),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .sat_cnt    (sat_cnt),
      .sat_clr    (sat_clr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] cnt_of(input int lane);
      return sat_cnt[lane*SW +: SW];
   endfunction

   // Reference cast: value * 2^11 / 2^16 rounded toward -inf, clamped to 16-bit range.
   function automatic void ref_cast(input logic [31:0] w, output logic [15:0] q, output logic s);
      longint v;
      longint f;
      v = longint'($signed(w));
      if (v >= 0) f = v / SCALE;
      else        f = -((-v + SCALE - 1) / SCALE);
      s = 1'b1;
      if (f > OMAX)      q = 16'h7FFF;
      else if (f < OMIN) q = 16'h8000;
      else begin
         q = 16'(f);
         s = 1'b0;
      end
   endfunction

   typedef struct {
      logic [31:0] w;
      int          lane;
      logic [15:0] exp_dout;
      logic        exp_sat;
   } vec_t;

   vec_t vt[10];

   // Behavioural model state for the random phase.
   int          m_ptr;
   logic        m_valid;
   logic [15:0] m_dout;
   int          m_lane;
   logic        m_sat;
   int          m_cnt[N];

   initial begin
      int          exp_cnt[N];
      logic [31:0] w;
      logic [15:0] q;
      logic        s;
      logic [3:0]  exp_rdy;
      logic        m_free;
      int          g;
      int          idx;

      vt[0] = '{32'h0001_8000, 0, 16'h0C00, 1'b0};   // 1.5
      vt[1] = '{32'h0064_0000, 2, 16'h7FFF, 1'b1};   // 100.0
      vt[2] = '{32'hFF9C_0000, 2, 16'h8000, 1'b1};   // -100.0
      vt[3] = '{32'hFFFE_8000, 1, 16'hF400, 1'b0};   // -1.5
      vt[4] = '{32'hFFFF_FFFF, 3, 16'hFFFF, 1'b0};   // tiny negative floors to -1 lsb
      vt[5] = '{32'h0000_001F, 0, 16'h0000, 1'b0};   // tiny positive truncates to 0
      vt[6] = '{32'h000F_FFFF, 1, 16'h7FFF, 1'b0};   // just below +16: exact max, no clamp
      vt[7] = '{32'h0010_0000, 3, 16'h7FFF, 1'b1};   // +16.0 clamps
      vt[8] = '{32'hFFF0_0000, 0, 16'h8000, 1'b0};   // -16.0 is exact min
      vt[9] = '{32'hFFEF_FFFF, 1, 16'h8000, 1'b1};   // below -16 clamps

      // ---------------- reset state ----------------
      rst_n      = 1'b0;
      din        = '0;
      din_valid  = '1;
      lane_mask  = '1;
      dout_ready = 1'b1;
      sat_clr    = 1'b0;
      #2;
      check("reset_din_ready", din_ready, 0);
      check("reset_dout_valid", dout_valid, 0);
      check("reset_dout", dout, 0);
      check("reset_dout_lane", dout_lane, 0);
      check("reset_dout_sat", dout_sat, 0);
      check("reset_sat_cnt", sat_cnt, 0);
      din_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- cast vector table ----------------
      foreach (exp_cnt[i]) exp_cnt[i] = 0;
      for (int i = 0; i < 10; i++) begin
         din_valid = '0;
         din[vt[i].lane*DW +: DW] = vt[i].w;
         din_valid[vt[i].lane] = 1'b1;
         #1;
         check($sformatf("vec%0d_din_ready", i), din_ready, 64'(4'b0001 << vt[i].lane));
         tick();
         din_valid = '0;
         check($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
         check($sformatf("vec%0d_lane", i), dout_lane, vt[i].lane);
         check($sformatf("vec%0d_sat", i), dout_sat, vt[i].exp_sat);
         check($sformatf("vec%0d_valid", i), dout_valid, 1);
         if (vt[i].exp_sat) exp_cnt[vt[i].lane]++;
      end
      for (int i = 0; i < N; i++) check($sformatf("sat_cnt%0d", i), cnt_of(i), exp_cnt[i]);
      tick();
      check("drain_valid", dout_valid, 0);

      // sat_clr wins over a same-cycle saturating transfer
      din[0 +: DW] = 32'h0064_0000;
      din_valid    = 4'b0001;
      sat_clr      = 1'b1;
      tick();
      sat_clr   = 1'b0;
      din_valid = '0;
      check("clr_prio_dout_sat", dout_sat, 1);
      for (int i = 0; i < N; i++) check($sformatf("clr_sat_cnt%0d", i), cnt_of(i), 0);

      // ---------------- mid-stream reset, then fairness ----------------
      for (int i = 0; i < N; i++) din[i*DW +: DW] = 32'(i) << 16;   // lane i carries i.0
      din_valid = '1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", dout_valid, 0);
      check("async_rst_dout", dout, 0);
      check("async_rst_lane", dout_lane, 0);
      check("async_rst_din_ready", din_ready, 0);
      tick();
      check("rst_edge_no_xfer", dout_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_first_grant", din_ready, 4'b0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("fair%0d_lane", k), dout_lane, k % N);
         check($sformatf("fair%0d_dout", k), dout, (k % N) * 2048);
         check($sformatf("fair%0d_valid", k), dout_valid, 1);
      end

      // ---------------- backpressure ----------------
      tick();                           // lane 0
      tick();                           // lane 1 now in the output register
      dout_ready = 1'b0;
      #1;
      check("bp_din_ready", din_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("bp%0d_lane", k), dout_lane, 1);
         check($sformatf("bp%0d_dout", k), dout, 16'h0800);
         check($sformatf("bp%0d_valid", k), dout_valid, 1);
         check($sformatf("bp%0d_din_ready", k), din_ready, 0);
      end
      dout_ready = 1'b1;
      #1;
      check("bp_release_ready", din_ready, 4'b0100);
      tick();
      check("bp_release_lane", dout_lane, 2);

      // ---------------- masking ----------------
      lane_mask = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("mask%0d_lane", k), dout_lane, (k % 2 == 0) ? 3 : 1);
      end
      lane_mask = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("mask1only%0d_lane", k), dout_lane, 1);
      end

      // ---------------- randomized traffic vs model ----------------
      din_valid = '0;
      lane_mask = '1;
      rst_n     = 1'b0;
      #3;
      @(negedge clk);
      rst_n   = 1'b1;
      m_ptr   = 0;
      m_valid = 1'b0;
      m_dout  = '0;
      m_lane  = 0;
      m_sat   = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;

      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < N; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w = {{12{w[19]}}, w[19:0]};
            din[i*DW +: DW] = w;
         end
         din_valid  = 4'($urandom);
         lane_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         dout_ready = ($urandom_range(0, 3) != 0);
         sat_clr    = ($urandom_range(0, 40) == 0);
         #1;
         m_free = !m_valid || dout_ready;
         g = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && din_valid[idx] && lane_mask[idx]) g = idx;
         end
         exp_rdy = (g >= 0 && m_free) ? 4'(1 << g) : 4'b0;
         check("rand_din_ready", din_ready, exp_rdy);
         @(posedge clk);
         if (exp_rdy != 4'b0) begin
            ref_cast(din[g*DW +: DW], q, s);
            m_dout  = q;
            m_lane  = g;
            m_sat   = s;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
            if (s && !sat_clr && m_cnt[g] < 65535) m_cnt[g]++;
         end else if (dout_ready) begin
            m_valid = 1'b0;
         end
         if (sat_clr) foreach (m_cnt[i]) m_cnt[i] = 0;
         #1;
         check("rand_valid", dout_valid, m_valid);
         check("rand_dout", dout, m_dout);
         check("rand_lane", dout_lane, m_lane);
         check("rand_sat", dout_sat, m_sat);
         for (int i = 0; i < N; i++) check($sformatf("rand_sat_cnt%0d", i), cnt_of(i), m_cnt[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cast_scheduler.md
# cast_scheduler

Round-robin scheduler that shares one saturating signed fixed-point cast stage among `N_LANES` correlator output streams. Each lane presents a wide accumulator word with a valid/ready handshake. The block grants one lane per cycle, requantizes the word to the output format and emits it tagged with its lane index. It also keeps per-lane saturation counters. It sits between the correlator accumulators and the readout/packetizer.

## Interface
- `N_LANES`, 4: number of requesting lanes (≥2)
- `DIN_WIDTH`, 32: input word width, signed two's complement
- `DIN_POINT`, 16: input fractional bits
- `DOUT_WIDTH`, 16: output word width, signed
- `DOUT_POINT`, 11: output fractional bits
- `SAT_CNT_WIDTH`, 16: per-lane saturation counter width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `din` in `N_LANES*DIN_WIDTH`: lane i occupies `[i*DIN_WIDTH +: DIN_WIDTH]`
- `din_valid` in `N_LANES`: per-lane request
- `din_ready` out `N_LANES`: per-lane accept, at most one bit high
- `lane_mask` in `N_LANES`: 1 = lane eligible for grant
- `dout` out `DOUT_WIDTH`: cast result
- `dout_lane` out `clog2(N_LANES)`: source lane of `dout`
- `dout_sat` out 1: `dout` was saturated
- `dout_valid` out 1: output holds a word
- `dout_ready` in 1: downstream accept
- `sat_cnt` out `N_LANES*SAT_CNT_WIDTH`: per-lane saturation event counts
- `sat_clr` in 1: synchronous clear of all `sat_cnt`

## Operation
- Eligible lanes: `din_valid[i] & lane_mask[i]`.
- Round-robin order: search starts at pointer `ptr`, wraps modulo `N_LANES`, first eligible lane wins.
  - `ptr` resets to 0.
  - After a transfer from lane g, `ptr` ← (g+1) mod `N_LANES`.
  - `ptr` does not move when nothing transfers.
- Output slot free: `free = ~dout_valid | dout_ready`.
- `din_ready[g] = grant[g] & free`. This path is combinational from `din_valid`, `lane_mask` and `dout_ready`.
- Transfer occurs when `din_valid[g] & din_ready[g]`. On a transfer, the output register loads:
  - `cast(din_g)`
  - `dout_lane = g`
  - `dout_sat`
  - `dout_valid = 1`
- `dout_ready` with no new transfer clears `dout_valid`.
- `dout_valid & ~dout_ready`: `dout`, `dout_lane` and `dout_sat` are held stable.
- Cast rules:
  - Fraction: keep the top `DOUT_POINT` fractional bits (truncate toward −∞). If `DOUT_POINT > DIN_POINT`, zero-fill the LSBs.
  - Integer, widening: sign-extend.
  - Integer, narrowing: saturate to the full output range, max `0111…1` and min `1000…0`. This is symmetric with respect to the output word, so it is not integer-part-only saturation.
  - `dout_sat` = 1 whenever a clamp occurs.
- `sat_cnt[g]` increments on each saturated transfer from lane g and sticks at all-ones.
- `sat_clr` takes priority over a same-cycle increment.
- `lane_mask` changes take effect on the same cycle's grant. A word already in the output register is unaffected.

## Timing
- Latency: 1 cycle, from a transfer edge to `dout_valid`.
- Throughput: 1 word/cycle when `dout_ready` is held high.
- Reset values:
  - `dout`, `dout_lane`, `dout_sat`, `dout_valid`, `sat_cnt`: 0
  - `ptr`: 0
  - `din_ready`: 0 while `rst_n` is low
- Reset mid-stream: the in-flight output word is discarded. No transfer counts on the edge where `rst_n` is low.
- No eligible lane: `din_ready` is all 0 and the output register drains normally.
- `din_valid` may drop without a transfer; there is no stickiness requirement on requesters.

## Structure
- Package `cast_sched_pkg`:
  - `LANE_W = $clog2(N_LANES)`
  - `DIN_INT`/`DOUT_INT` localparams
  - functions for output max/min constants and the saturating cast
- Sub-module `rr_arbiter`:
  - parameter `N`
  - inputs: `req`, `advance`
  - outputs: one-hot `grant`, encoded `grant_idx`
  - holds `ptr`, async active-low reset
- The top level holds the output register, cast logic and counters.

## Test plan
- **Single word:** lane 0, `din`=0x0001_8000 (1.5) → one cycle later `dout`=0x0C00, `dout_lane`=0, `dout_sat`=0.
- **Saturation:**
  - lane 2, 100.0 (0x0064_0000) → `dout`=0x7FFF, `dout_sat`=1.
  - −100.0 (0xFF9C_0000) → 0x8000.
  - `sat_cnt[2]`=2; after `sat_clr`, 0.
- **Fairness:** all 4 lanes valid, `dout_ready`=1 → `dout_lane` sequence 0,1,2,3,0,1…, one word per cycle.
- **Backpressure:** `dout_ready`=0 for 3 cycles with lane 1 word pending → `dout` held; all `din_ready`=0. On release, the next lane in order transfers.
- **Masking:** `lane_mask`=0b1010, all lanes valid → only lanes 1,3 alternate. Clearing bit 3 mid-run → lane 1 only.
- **Reset:** `rst_n` low mid-stream → all outputs 0 asynchronously. After release, the first grant goes to lane 0.
